// File: rtl/mem_access_ctrl_if.sv
// Request/grant bus between the CPU control unit and the memory access controller.
// Ports (master = control unit, slave = mem_access_ctrl):
//   fetch_req, data_req, data_we, exc_req, exc_code : requests, master -> slave
//   addr_sel, mem_wr, ir_load, mdr_load             : datapath controls, slave -> master
//   fetch_done, data_done, exc_done, busy           : completion/status, slave -> master
interface mem_access_ctrl_if;
    logic       fetch_req;
    logic       data_req;
    logic       data_we;
    logic       exc_req;
    logic [1:0] exc_code;
    logic [2:0] addr_sel;
    logic       mem_wr;
    logic       ir_load;
    logic       mdr_load;
    logic       fetch_done;
    logic       data_done;
    logic       exc_done;
    logic       busy;

    modport master (
        output fetch_req, data_req, data_we, exc_req, exc_code,
        input  addr_sel, mem_wr, ir_load, mdr_load,
        input  fetch_done, data_done, exc_done, busy
    );

    modport slave (
        input  fetch_req, data_req, data_we, exc_req, exc_code,
        output addr_sel, mem_wr, ir_load, mdr_load,
        output fetch_done, data_done, exc_done, busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the shared memory address path of the multicycle CPU.
// Grants one of fetch / data / exception-vector requests at a time (priority
// exc > data > fetch), drives the address-mux selector and pulses mem_wr,
// ir_load, mdr_load and a done pulse. Sequence: IDLE -> ACCESS -> WAIT -> DONE.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   bus      : mem_access_ctrl_if.slave (requests in, controls/done/busy out)
//   acc_cnt  : [31:0] completed-access count  (only with MEM_ACC_CNT_EN)
//   wr_cnt   : [15:0] completed-store count   (only with MEM_ACC_CNT_EN)
// Parameter WAIT_CYC (0..15): read latency cycles after the address cycle.
// Optional feature macro: MEM_ACC_CNT_EN (adds the access/store counters).
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
`ifdef MEM_ACC_CNT_EN
    ,
    output logic [31:0]       acc_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEL_W = 3;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic             SKIP_WAIT = (WAIT_CYC == 0);

    localparam logic [SEL_W-1:0] SEL_PC     = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_ALUOUT = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_ZERO   = SEL_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_FETCH,
        SRC_DATA,
        SRC_EXC
    } src_t;

    state_t            state;
    src_t              src_q;
    logic              we_q;
    logic [CNT_W-1:0]  wait_cnt;

    src_t              grant_src;
    logic              grant_any;
    logic              grant_store;
    logic [SEL_W-1:0]  grant_sel;
    logic              enter_done;

    // Fixed-priority arbitration and the selector for the would-be winner.
    always_comb begin
        grant_src   = SRC_FETCH;
        grant_any   = bus.exc_req | bus.data_req | bus.fetch_req;
        grant_store = 1'b0;
        grant_sel   = SEL_PC;
        if (bus.exc_req) begin
            grant_src = SRC_EXC;
            // Vector addresses 253/254/255 sit on selectors 2/3/4; code 3 has no vector.
            grant_sel = (bus.exc_code == 2'd3) ? SEL_ZERO
                                               : SEL_W'(bus.exc_code) + SEL_W'(2);
        end else if (bus.data_req) begin
            grant_src   = SRC_DATA;
            grant_store = bus.data_we;
            grant_sel   = SEL_ALUOUT;
        end
    end

    // The cycle after this one is DONE.
    always_comb begin
        enter_done = 1'b0;
        if (state == ST_ACCESS && SKIP_WAIT) begin
            enter_done = 1'b1;
        end else if (state == ST_WAIT && wait_cnt == WAIT_LAST) begin
            enter_done = 1'b1;
        end
    end

    // State sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            src_q          <= SRC_FETCH;
            we_q           <= 1'b0;
            wait_cnt       <= '0;
            bus.addr_sel   <= SEL_PC;
            bus.mem_wr     <= 1'b0;
            bus.ir_load    <= 1'b0;
            bus.mdr_load   <= 1'b0;
            bus.fetch_done <= 1'b0;
            bus.data_done  <= 1'b0;
            bus.exc_done   <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef MEM_ACC_CNT_EN
            acc_cnt        <= '0;
            wr_cnt         <= '0;
`endif
        end else begin
            bus.mem_wr     <= 1'b0;
            bus.ir_load    <= 1'b0;
            bus.mdr_load   <= 1'b0;
            bus.fetch_done <= 1'b0;
            bus.data_done  <= 1'b0;
            bus.exc_done   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state        <= ST_ACCESS;
                        src_q        <= grant_src;
                        we_q         <= grant_store;
                        bus.addr_sel <= grant_sel;
                        bus.mem_wr   <= grant_store;
                        bus.busy     <= 1'b1;
                    end else begin
                        bus.addr_sel <= SEL_PC;
                        bus.busy     <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= '0;
                    state    <= SKIP_WAIT ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    bus.addr_sel <= SEL_PC;
                    bus.busy     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (enter_done) begin
                case (src_q)
                    SRC_FETCH: begin
                        bus.ir_load    <= 1'b1;
                        bus.fetch_done <= 1'b1;
                    end
                    SRC_DATA: begin
                        bus.mdr_load  <= ~we_q;
                        bus.data_done <= 1'b1;
                    end
                    SRC_EXC: begin
                        bus.mdr_load <= 1'b1;
                        bus.exc_done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

`ifdef MEM_ACC_CNT_EN
            if (state == ST_DONE) begin
                acc_cnt <= acc_cnt + 32'd1;
                if (src_q == SRC_DATA && we_q) begin
                    wr_cnt <= wr_cnt + 16'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (WAIT_CYC 1, 0, 3) driven by
// randomized level requesters and checked cycle-by-cycle against a
// transaction-timeline model of the expected outputs.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       fetch_req [3];
    logic       data_req  [3];
    logic       data_we   [3];
    logic       exc_req   [3];
    logic [1:0] exc_code  [3];
    logic [9:0] obs       [3];
`ifdef MEM_ACC_CNT_EN
    logic [31:0] acc_cnt [3];
    logic [15:0] wr_cnt  [3];
`endif

    mem_access_ctrl_if bus0 ();
    mem_access_ctrl_if bus1 ();
    mem_access_ctrl_if bus2 ();

    assign bus0.fetch_req = fetch_req[0];
    assign bus0.data_req  = data_req[0];
    assign bus0.data_we   = data_we[0];
    assign bus0.exc_req   = exc_req[0];
    assign bus0.exc_code  = exc_code[0];
    assign bus1.fetch_req = fetch_req[1];
    assign bus1.data_req  = data_req[1];
    assign bus1.data_we   = data_we[1];
    assign bus1.exc_req   = exc_req[1];
    assign bus1.exc_code  = exc_code[1];
    assign bus2.fetch_req = fetch_req[2];
    assign bus2.data_req  = data_req[2];
    assign bus2.data_we   = data_we[2];
    assign bus2.exc_req   = exc_req[2];
    assign bus2.exc_code  = exc_code[2];

    // {addr_sel[9:7], mem_wr, ir_load, mdr_load, fetch_done, data_done, exc_done, busy}
    assign obs[0] = {bus0.addr_sel, bus0.mem_wr, bus0.ir_load, bus0.mdr_load,
                     bus0.fetch_done, bus0.data_done, bus0.exc_done, bus0.busy};
    assign obs[1] = {bus1.addr_sel, bus1.mem_wr, bus1.ir_load, bus1.mdr_load,
                     bus1.fetch_done, bus1.data_done, bus1.exc_done, bus1.busy};
    assign obs[2] = {bus2.addr_sel, bus2.mem_wr, bus2.ir_load, bus2.mdr_load,
                     bus2.fetch_done, bus2.data_done, bus2.exc_done, bus2.busy};

    mem_access_ctrl #(.WAIT_CYC(1)) u_dut_w1 (
        .clk(clk), .reset(reset), .bus(bus0)
`ifdef MEM_ACC_CNT_EN
        , .acc_cnt(acc_cnt[0]), .wr_cnt(wr_cnt[0])
`endif
    );
    mem_access_ctrl #(.WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .bus(bus1)
`ifdef MEM_ACC_CNT_EN
        , .acc_cnt(acc_cnt[1]), .wr_cnt(wr_cnt[1])
`endif
    );
    mem_access_ctrl #(.WAIT_CYC(3)) u_dut_w3 (
        .clk(clk), .reset(reset), .bus(bus2)
`ifdef MEM_ACC_CNT_EN
        , .acc_cnt(acc_cnt[2]), .wr_cnt(wr_cnt[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pack(input logic [2:0] sel, input logic wr, input logic ir,
                                        input logic mdr, input logic fd, input logic dd,
                                        input logic ed, input logic bsy);
        return {sel, wr, ir, mdr, fd, dd, ed, bsy};
    endfunction

    task automatic drive(input int d, input logic fr, input logic dr, input logic we,
                         input logic er, input logic [1:0] code);
        fetch_req[d] = fr;
        data_req[d]  = dr;
        data_we[d]   = we;
        exc_req[d]   = er;
        exc_code[d]  = code;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Randomized run on instance d; the model expands each grant into its output timeline.
    task automatic run_rand(input int d, input int wc, input int ncyc);
        logic [9:0] q[$];
        logic [9:0] exp;
        logic       was_idle, fr, dr, er, we;
        logic [1:0] code;
        logic [2:0] sel;
        logic       is_fetch, is_load, is_store, is_exc;
        int         total, n_acc, n_st;
        fr = 1'b0; dr = 1'b0; er = 1'b0;
        n_acc = 0; n_st = 0;
        total = ncyc + 3 * (wc + 4) + 4;
        do_reset();
        for (int cyc = 0; cyc < total; cyc++) begin
            @(negedge clk);
            was_idle = (q.size() == 0);
            exp = was_idle ? 10'd0 : q.pop_front();
            chk($sformatf("w%0d_cyc%0d", wc, cyc), 32'(obs[d]), 32'(exp));
            if (exp[3]) fr = 1'b0;
            if (exp[2]) dr = 1'b0;
            if (exp[1]) er = 1'b0;
            if (cyc < ncyc) begin
                if (!fr && $urandom_range(0, 2) == 0) fr = 1'b1;
                if (!dr && $urandom_range(0, 3) == 0) dr = 1'b1;
                if (!er && $urandom_range(0, 5) == 0) er = 1'b1;
            end
            we   = 1'($urandom);
            code = 2'($urandom);
            drive(d, fr, dr, we, er, code);
            if (was_idle && (fr || dr || er)) begin
                is_exc   = er;
                is_store = !er && dr && we;
                is_load  = !er && dr && !we;
                is_fetch = !er && !dr;
                if (is_exc)      sel = (code == 2'd3) ? 3'd7 : 3'(code) + 3'd2;
                else if (dr)     sel = 3'd1;
                else             sel = 3'd0;
                n_acc++;
                if (is_store) n_st++;
                q.push_back(pack(sel, is_store, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                for (int w = 0; w < wc; w++)
                    q.push_back(pack(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                q.push_back(pack(sel, 1'b0, is_fetch, is_load || is_exc, is_fetch,
                                 is_load || is_store, is_exc, 1'b1));
            end
        end
        chk($sformatf("w%0d_drain", wc), 32'(q.size()), 32'd0);
        chk($sformatf("w%0d_reqs_clear", wc), {29'd0, fr, dr, er}, 32'd0);
`ifdef MEM_ACC_CNT_EN
        chk($sformatf("w%0d_acc_cnt", wc), acc_cnt[d], 32'(n_acc));
        chk($sformatf("w%0d_wr_cnt", wc), 32'(wr_cnt[d]), 32'(n_st));
`endif
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("reset_d%0d", d), 32'(obs[d]), 32'd0);
        reset = 1'b0;

        // Fetch on WAIT_CYC=1, then reset while in WAIT: access aborted, no done pulse.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        chk("abort_access", 32'(obs[0]), 32'(pack(3'd0, 0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
        chk("abort_wait", 32'(obs[0]), 32'(pack(3'd0, 0, 0, 0, 0, 0, 0, 1)));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_reset", 32'(obs[0]), 32'd0);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(obs[0]), 32'd0);

        run_rand(0, 1, 400);
        run_rand(1, 0, 400);
        run_rand(2, 3, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
